// File: rtl/al_clock_pkg.sv
// Shared alarm-clock types: BCD digit/time, state encoding and the 24-hour
// legality check used on commit.
package al_clock_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t ms_hour;
      bcd_digit_t ls_hour;
      bcd_digit_t ms_min;
      bcd_digit_t ls_min;
   } bcd_time_t;

   typedef enum logic [1:0] {IDLE, ENTRY, COMMIT_T, COMMIT_A} te_state_t;

   localparam int DEF_TIMEOUT_SECS = 10;

   // Unentered leading digits are zero, so a partial entry checks naturally.
   function automatic logic is_valid_time(input bcd_time_t t);
      logic hour_ok;
      hour_ok = (t.ms_hour <= 4'd2) &&
                (t.ls_hour <= ((t.ms_hour == 4'd2) ? 4'd3 : 4'd9));
      is_valid_time = hour_ok && (t.ms_min <= 4'd5) && (t.ls_min <= 4'd9);
   endfunction

endpackage

// File: rtl/al_key_shift_reg.sv
// Four-digit BCD shift buffer. Clear together with shift loads a lone digit,
// which is how a fresh entry starts.
module al_key_shift_reg (
   input  logic        clk,
   input  logic        shift_en,
   input  logic [3:0]  digit,
   input  logic        clear,
   output logic [15:0] key_buffer
);

   always_ff @(posedge clk) begin
      if (shift_en)
         key_buffer <= {(clear ? 12'h000 : key_buffer[11:0]), digit};
      else if (clear)
         key_buffer <= 16'h0000;
   end

endmodule

// File: rtl/al_time_entry.sv
// Keypad time-entry controller: collects digits, validates on a button press
// and drives the time/alarm load strobes with the committed BCD value.
module al_time_entry
   import al_clock_pkg::*;
#(
   parameter int TIMEOUT_SECS = DEF_TIMEOUT_SECS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        one_second,
   input  logic [3:0]  key,
   input  logic        key_valid,
   input  logic        time_button,
   input  logic        alarm_button,
   output logic [15:0] key_buffer,
   output logic        show_keyboard,
   output logic [15:0] time_out,
   output logic        load_new_time,
   output logic        load_new_alarm,
   output logic        entry_error
);

   localparam int CW = $clog2(TIMEOUT_SECS + 1);

   te_state_t      state, nxt;
   logic [CW-1:0]  cnt;
   logic           legal_key, btn, buf_ok, expire;
   logic           shift_en, clr_buf, err;

   assign legal_key = key_valid && (key <= 4'd9);
   assign btn       = time_button || alarm_button;
   assign buf_ok    = is_valid_time(key_buffer);
   assign expire    = one_second && (cnt == CW'(TIMEOUT_SECS - 1));

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   // Priority inside ENTRY: buttons (time first), then keys, then timeout.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (legal_key) nxt = ENTRY;
         ENTRY: begin
            if (time_button)       nxt = buf_ok ? COMMIT_T : ENTRY;
            else if (alarm_button) nxt = buf_ok ? COMMIT_A : ENTRY;
            else if (legal_key)    nxt = ENTRY;
            else if (expire)       nxt = IDLE;
         end
         default:  nxt = IDLE;
      endcase
   end

   always_comb begin
      shift_en = 1'b0;
      clr_buf  = 1'b0;
      err      = 1'b0;
      case (state)
         IDLE: begin
            shift_en = legal_key;
            clr_buf  = 1'b1;
         end
         ENTRY: begin
            shift_en = legal_key && !btn;
            clr_buf  = (nxt == IDLE);
            err      = btn && !buf_ok;
         end
         default: clr_buf = 1'b1;
      endcase
   end

   al_key_shift_reg u_shift (
      .clk        (clk),
      .shift_en   (reset && shift_en),
      .digit      (key),
      .clear      (!reset || clr_buf),
      .key_buffer (key_buffer)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         time_out       <= 16'h0000;
         load_new_time  <= 1'b0;
         load_new_alarm <= 1'b0;
         entry_error    <= 1'b0;
         show_keyboard  <= 1'b0;
         cnt            <= '0;
      end else begin
         load_new_time  <= (nxt == COMMIT_T);
         load_new_alarm <= (nxt == COMMIT_A);
         entry_error    <= err;
         show_keyboard  <= (nxt == ENTRY);
         if (nxt == COMMIT_T || nxt == COMMIT_A)
            time_out <= key_buffer;
         if (state != ENTRY || nxt != ENTRY || legal_key || btn)
            cnt <= '0;
         else if (one_second)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_al_time_entry.sv
// Directed bench: stimulus pushes expected strobe events, a negedge monitor
// pops and compares them; level outputs are checked inline.
module tb_al_time_entry;

   localparam int K_TIME = 0, K_ALARM = 1, K_ERR = 2;

   typedef struct {
      int          kind;
      logic [15:0] val;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        one_second = 1'b0;
   logic [3:0]  key = 4'h0;
   logic        key_valid = 1'b0;
   logic        time_button = 1'b0;
   logic        alarm_button = 1'b0;
   logic [15:0] key_buffer, time_out;
   logic        show_keyboard, load_new_time, load_new_alarm, entry_error;

   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   bit  done = 1'b0;

   always #5 clk = ~clk;

   al_time_entry #(.TIMEOUT_SECS(3)) dut (
      .clk(clk), .reset(reset), .one_second(one_second), .key(key),
      .key_valid(key_valid), .time_button(time_button), .alarm_button(alarm_button),
      .key_buffer(key_buffer), .show_keyboard(show_keyboard), .time_out(time_out),
      .load_new_time(load_new_time), .load_new_alarm(load_new_alarm),
      .entry_error(entry_error)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic press_key(input logic [3:0] k);
      key = k; key_valid = 1'b1;
      step();
      key_valid = 1'b0;
   endtask

   task automatic keys4(input logic [15:0] v);
      for (int i = 3; i >= 0; i--) press_key(v[i*4 +: 4]);
   endtask

   task automatic press(input logic t, input logic a);
      time_button = t; alarm_button = a;
      step();
      time_button = 1'b0; alarm_button = 1'b0;
   endtask

   task automatic expect_ev(input int kind, input logic [15:0] v);
      ev_t e;
      e.kind = kind; e.val = v;
      exp_q.push_back(e);
   endtask

   // Monitor: every strobe must match the oldest expected event.
   always @(negedge clk) begin
      if (!done && (load_new_time === 1'b1 || load_new_alarm === 1'b1 ||
                    entry_error === 1'b1)) begin
         int kind;
         logic [15:0] v;
         ev_t e;
         kind = load_new_time ? K_TIME : (load_new_alarm ? K_ALARM : K_ERR);
         v    = (kind == K_ERR) ? key_buffer : time_out;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: got kind %0d value %h expected none", kind, v);
         end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== v ||
                (load_new_time + load_new_alarm + entry_error) != 2'd1) begin
               failures++;
               $display("FAIL strobe_event: got kind %0d value %h expected kind %0d value %h",
                        kind, v, e.kind, e.val);
            end
         end
      end
   end

   initial begin
      step(); step();
      chk("rst_buffer", key_buffer, 16'h0000);
      chk("rst_time_out", time_out, 16'h0000);
      chk("rst_flags", {12'h0, show_keyboard, load_new_time, load_new_alarm, entry_error}, 16'h0);
      reset = 1'b1;
      step();
      // Buttons in IDLE are ignored (monitor flags any strobe).
      press(1'b1, 1'b0); press(1'b0, 1'b1); step();

      // Normal entry
      keys4(16'h1234);
      chk("entry_buffer", key_buffer, 16'h1234);
      chk("entry_show", {15'h0, show_keyboard}, 16'h1);
      expect_ev(K_TIME, 16'h1234);
      press(1'b1, 1'b0);
      step();
      chk("commit_idle_buffer", key_buffer, 16'h0000);
      chk("commit_idle_show", {15'h0, show_keyboard}, 16'h0);
      chk("time_out_hold", time_out, 16'h1234);

      // Illegal 24:00 rejected, then 23:59 to the alarm
      keys4(16'h2400);
      expect_ev(K_ERR, 16'h2400);
      press(1'b1, 1'b0);
      step();
      chk("err_buffer_kept", key_buffer, 16'h2400);
      chk("err_show", {15'h0, show_keyboard}, 16'h1);
      chk("err_no_load", time_out, 16'h1234);
      keys4(16'h2359);
      expect_ev(K_ALARM, 16'h2359);
      press(1'b0, 1'b1);
      step();

      // Overflow drops the oldest digit
      press_key(4'd9); keys4(16'h1230);
      chk("overflow_buffer", key_buffer, 16'h1230);
      expect_ev(K_ALARM, 16'h1230);
      press(1'b0, 1'b1);
      step();

      // Leading zeros
      press_key(4'd7);
      chk("single_digit", key_buffer, 16'h0007);
      expect_ev(K_TIME, 16'h0007);
      press(1'b1, 1'b0);
      step();

      // Timeout: an illegal key does not restart the count
      press_key(4'd5);
      one_second = 1'b1; step(); one_second = 1'b0;
      press_key(4'hB);
      chk("illegal_key_ignored", key_buffer, 16'h0005);
      one_second = 1'b1; step(); one_second = 1'b0;
      chk("pre_timeout_show", {15'h0, show_keyboard}, 16'h1);
      one_second = 1'b1; step(); one_second = 1'b0;
      chk("timeout_buffer", key_buffer, 16'h0000);
      chk("timeout_show", {15'h0, show_keyboard}, 16'h0);
      chk("timeout_time_out", time_out, 16'h0007);

      // Button beats a simultaneous key
      keys4(16'h1200);
      expect_ev(K_TIME, 16'h1200);
      key = 4'd8; key_valid = 1'b1;
      press(1'b1, 1'b0);
      key_valid = 1'b0;
      step();
      chk("prio_idle_buffer", key_buffer, 16'h0000);

      // Both buttons: time wins
      keys4(16'h1200);
      expect_ev(K_TIME, 16'h1200);
      press(1'b1, 1'b1);
      step();

      // Reset during COMMIT_T
      keys4(16'h0930);
      expect_ev(K_TIME, 16'h0930);
      press(1'b1, 1'b0);
      reset = 1'b0;
      step();
      chk("midrst_strobe", {15'h0, load_new_time}, 16'h0);
      chk("midrst_buffer", key_buffer, 16'h0000);
      chk("midrst_time_out", time_out, 16'h0000);
      chk("midrst_show", {15'h0, show_keyboard}, 16'h0);
      reset = 1'b1;
      step();
      press_key(4'd4);
      chk("post_rst_idle_entry", key_buffer, 16'h0004);

      step(); step();
      done = 1'b1;
      chk("pending_events", 16'(exp_q.size()), 16'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/al_time_entry.md
# al_time_entry

Keypad time-entry controller for the alarm clock. It collects BCD digits from the keypad decoder into a four-digit shift buffer and shows them on the display while the user types. On the "set time" or "set alarm" button it checks that the buffer holds a legal 24-hour time, then drives that value with a one-cycle load strobe. It is the writing side of the time counter's `time_in`/`load_new_time` interface, and it feeds the alarm register in the same way.

## Interface
- `TIMEOUT_SECS`, default 10: number of `one_second` ticks with no key activity before an entry is abandoned.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-low reset.
- `one_second`  in  1: one-cycle tick from the clock divider.
- `key`  in  4: digit from the keypad decoder; only 0–9 are legal.
- `key_valid`  in  1: one-cycle strobe qualifying `key`.
- `time_button`  in  1: one-cycle strobe, commit the buffer to the time counter.
- `alarm_button`  in  1: one-cycle strobe, commit the buffer to the alarm register.
- `key_buffer`  out  16: digits being entered, BCD {ms_hour, ls_hour, ms_min, ls_min}.
- `show_keyboard`  out  1: display mux select; 1 selects `key_buffer`.
- `time_out`  out  16: last committed BCD value.
- `load_new_time`  out  1: one-cycle strobe; `time_out` is valid during it.
- `load_new_alarm`  out  1: one-cycle strobe; `time_out` is valid during it.
- `entry_error`  out  1: one-cycle strobe, commit was rejected.

## Operation
- **States:** IDLE, ENTRY, COMMIT_T, COMMIT_A.
- **Reset (`reset`=0 at a clock edge):**
  - State goes to IDLE.
  - `key_buffer` = 16'h0000 and `time_out` = 16'h0000.
  - All strobes and `show_keyboard` = 0.
  - Timeout counter = 0.
  - Reset overrides everything, including a pending commit.
- **IDLE:**
  - `key_valid` with `key` ≤ 9: `key_buffer` ← {12'h000, key}, go to ENTRY.
  - Buttons are ignored.
- **ENTRY:**
  - `show_keyboard` = 1.
  - A legal digit shifts in: `key_buffer` ← {key_buffer[11:0], key}.
  - More than four digits keep shifting; the oldest digit is lost.
  - Any legal digit clears the timeout counter.
- **Illegal key codes (`key` > 9):** ignored in every state and do not clear the timeout counter.
- **Commit from ENTRY:** `time_button` goes to COMMIT_T and `alarm_button` goes to COMMIT_A, provided the buffer is a legal time.
- **Legal time:**
  - ms_hour ≤ 2.
  - ls_hour ≤ 9, and ls_hour ≤ 3 when ms_hour = 2.
  - ms_min ≤ 5.
  - ls_min ≤ 9.
  - Unentered leading digits are 0, so "7" means 00:07.
- **Illegal buffer on commit:** `entry_error` pulses for one cycle, the state stays ENTRY, `key_buffer` is kept, and the timeout counter is cleared.
- **COMMIT_T / COMMIT_A:**
  - `time_out` ← `key_buffer`.
  - The matching strobe pulses for one cycle.
  - On the next edge the state goes to IDLE and `key_buffer` clears to 0.
- **Timeout:**
  - In ENTRY, each `one_second` tick increments the counter.
  - When the counter reaches `TIMEOUT_SECS`, go to IDLE, clear `key_buffer`, and set `show_keyboard` = 0.
  - Nothing is loaded.
- **Simultaneous events:**
  - A button and `key_valid` in the same cycle: the button wins and the key is dropped.
  - `time_button` and `alarm_button` together: time wins.
  - A tick and a legal key in the same cycle: the key wins and the counter clears.
- **`time_out`:** holds its value between commits.

## Timing
- All outputs are registered.
- Key strobe sampled at edge N: `key_buffer` is updated from cycle N+1.
- Button sampled at edge N:
  - The strobe is high in cycle N+1 and `time_out` is valid from N+1.
  - At edge N+2 the block is in IDLE and `key_buffer` = 0.
- Keys arriving during cycle N+1 (the COMMIT state) are dropped.
- Timeout fires on the edge where the counter reaches `TIMEOUT_SECS`, which is `TIMEOUT_SECS` ticks after the last legal key.
- Timeout counter width is $clog2(TIMEOUT_SECS+1).

## Structure
- **Shared package `al_clock_pkg`:**
  - `bcd_digit_t` (4-bit).
  - `bcd_time_t` (packed struct of four digits).
  - `is_valid_time()` function.
  - `TIMEOUT_SECS` default constant.
- **Sub-module `al_key_shift_reg`:**
  - 4-digit shift register with a synchronous clear.
  - Inputs: shift enable, digit, clear.
  - Output: 16-bit buffer.
- The FSM, the timeout counter and validation stay in the top level.

## Test plan
- **Normal time entry:** reset, keys 1,2,3,4, `time_button` -> `key_buffer` 16'h1234 before the commit; `load_new_time` high one cycle with `time_out` = 16'h1234; then IDLE with buffer 0 and `show_keyboard` 0.
- **Validation:**
  - Keys 2,4,0,0, `time_button` -> `entry_error` pulse, no load, buffer stays 16'h2400.
  - Keys 2,3,5,9, `alarm_button` -> `load_new_alarm` with 16'h2359.
- **Shift overflow and leading zeros:**
  - Keys 9,1,2,3,0, `alarm_button` -> buffer 16'h1230, alarm loaded with 16'h1230.
  - Single key 7 then `time_button` -> 16'h0007.
- **Timeout:** `TIMEOUT_SECS`=3; key 5, then three ticks -> IDLE, no strobe, `time_out` unchanged; a key 0xB in between does not extend the timeout.
- **Priority:**
  - Key 8 together with `time_button` after 1,2,0,0 -> load 16'h1200, digit 8 dropped.
  - Both buttons together -> only `load_new_time` pulses.
- **Reset mid-operation:** `reset`=0 during COMMIT_T -> strobe low on the following cycle, all outputs return to reset values, state IDLE.
